// File: rtl/result_uart_tx.sv
// result_uart_tx
//   Buffers 8-bit results (from an accelerator stage or written by a host)
//   in a small FIFO and sends them as UART frames on a registered tx line.
//   The frame is start bit (low), 8 data bits LSB-first, an optional even
//   parity bit and a stop bit (high). Each bit lasts DIV+1 clocks. DIV is
//   captured when a frame starts, so a DIV write during a frame only takes
//   effect from the next frame onward.
//
//   Optional feature macro: RESULT_TX_PARITY_EN adds an even-parity bit
//   between the data bits and the stop bit.
//
// Handshake: a result is taken on every rising clk edge where res_valid and
//   res_ready are both high. res_ready is low when the FIFO is full, and also
//   while the host writes TXDATA, because the host push has priority.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   res_data/valid     result input, res_ready is its accept signal
//   address            register address (0 DIV, 1 STATUS, 2 TXDATA)
//   data_write/data_in host write strobe and write data
//   data_out           host read data, combinational from address
//   tx                 serial output, idle high
//   busy               high while a frame is on tx
//   dbg_state_o        current FSM state, for debug and checkers
//
// Parameters
//   FIFO_DEPTH  number of buffered entries (power of two, at least 2)
//   DIV_RESET   reset value of the DIV register
module result_uart_tx #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DIV_RESET  = 8'h3F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] res_data,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       tx,
  output logic       busy,
  output logic [2:0] dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef RESULT_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    div_q, div_d;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shr_q, shr_d;
  logic [7:0]    divl_q, divl_d;
  logic          tx_q, tx_d;

  logic          full, empty, host_push, host_ok, res_push, push, pop, bit_end;
  logic [7:0]    push_data;
  logic [2:0]    lvl3;

  // FIFO bookkeeping
  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign empty     = (level_q == '0);
  assign host_push = data_write && (address == 4'h2);
  assign res_ready = !full && !host_push;
  // A host write to a full FIFO still lands if the FSM pops in that cycle.
  assign host_ok   = host_push && (!full || pop);
  assign res_push  = res_valid && res_ready;
  assign push      = host_ok || res_push;
  assign push_data = host_push ? data_in : res_data;
  assign level_d   = level_q + LW'(push) - LW'(pop);

  always_comb begin
    ovf_d = ovf_q;
    div_d = div_q;
    if (data_write && (address == 4'h0)) div_d = data_in;
    if (data_write && (address == 4'h1)) ovf_d = 1'b0;
    if (host_push && full && !pop)       ovf_d = 1'b1;
  end

  // Frame sequencer
  assign bit_end = (cnt_q == divl_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shr_d   = shr_q;
    divl_d  = divl_q;
    pop     = 1'b0;
    if (state_q != IDLE) cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          shr_d   = mem_q[rd_ptr_q];
          divl_d  = div_q;
          cnt_d   = 8'd0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef RESULT_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next frame when data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
            shr_d   = mem_q[rd_ptr_q];
            divl_d  = div_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is derived from the next state so the registered line lines up
  // exactly with state_q.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shr_d[bit_d];
`ifdef RESULT_TX_PARITY_EN
      PARITY:  tx_d = ^shr_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DIV_RESET;
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      bit_q    <= 3'd0;
      shr_q    <= 8'd0;
      divl_q   <= 8'd0;
      tx_q     <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shr_q    <= shr_d;
      divl_q   <= divl_d;
      tx_q     <= tx_d;
    end
  end

  // Storage is not reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign tx          = tx_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;
  assign lvl3        = 3'(level_q);

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0:    data_out = div_q;
      4'h1:    data_out = {1'b0, ovf_q, busy, full, 1'b0, lvl3};
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_result_uart_tx.sv
module tb_result_uart_tx;

  localparam int DEPTH = 4;
`ifdef RESULT_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] res_data = 8'h00;
  logic       res_valid = 1'b0;
  logic       res_ready;
  logic [3:0] address = 4'h0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       tx, busy;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  result_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(8'h3F)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .address(address), .data_write(data_write), .data_in(data_in),
    .data_out(data_out), .tx(tx), .busy(busy), .dbg_state_o(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO contents as a queue, the frame as a bit list
  // plus elapsed cycles; expected tx = bit[elapsed / (DIV+1)].
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  int         m_per = 1;
  logic       m_bits [0:10];
  logic [7:0] m_div = 8'h3F;
  logic       m_ovf = 1'b0;

  function automatic void start_frame(input logic [7:0] b);
    m_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
    m_bits[9]  = (NB == 11) ? ^b : 1'b1;
    m_bits[10] = 1'b1;
    m_per    = int'(m_div) + 1;
    m_pos    = 0;
    m_active = 1'b1;
    sent_q.push_back(b);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_p
    logic [7:0] b;
    bit ending, pop_now, full_now, host;
    if (!rst_n) begin
      exp_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_div    = 8'h3F;
      m_ovf    = 1'b0;
    end else begin
      ending   = m_active && (m_pos == NB * m_per - 1);
      pop_now  = (!m_active || ending) && (exp_q.size() > 0);
      full_now = (exp_q.size() == DEPTH);
      host     = data_write && (address == 4'h2);
      if (pop_now) begin
        b = exp_q.pop_front();
        start_frame(b);
      end else if (ending) begin
        m_active = 1'b0;
      end else if (m_active) begin
        m_pos++;
      end
      if (host) begin
        if (!full_now || pop_now) exp_q.push_back(data_in);
        else m_ovf = 1'b1;
      end else if (res_valid && !full_now) begin
        exp_q.push_back(res_data);
      end
      if (data_write && address == 4'h0) m_div = data_in;
      if (data_write && address == 4'h1) m_ovf = 1'b0;
    end
  end

  function automatic logic [7:0] model_rd(input logic [3:0] a);
    logic [2:0] lv;
    lv = 3'(exp_q.size());
    case (a)
      4'h0:    return m_div;
      4'h1:    return {1'b0, m_ovf, m_active, (exp_q.size() == DEPTH), 1'b0, lv};
      default: return 8'h00;
    endcase
  endfunction

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin : cmp_p
    logic exp_tx;
    exp_tx = m_active ? m_bits[m_pos / m_per] : 1'b1;
    check("tx", 32'(tx), 32'(exp_tx));
    check("busy", 32'(busy), 32'(m_active));
    check("res_ready", 32'(res_ready),
          32'((exp_q.size() < DEPTH) && !(data_write && address == 4'h2)));
    check("data_out", 32'(data_out), 32'(model_rd(address)));
  end

  // Longest continuous busy run, cleared on request
  bit run_clr = 1'b0;
  int run_len = 0;
  int max_run = 0;
  always @(negedge clk) begin
    if (run_clr) begin
      run_len = 0;
      max_run = 0;
    end else if (busy) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  // Driver tasks
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a; data_in = d; data_write = 1'b1;
    cyc();
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    address = a;
    #1;
    v = data_out;
  endtask

  task automatic send_res(input logic [7:0] d);
    res_data = d; res_valid = 1'b1;
    cyc();
    res_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < budget) begin
      cyc();
      k++;
    end
    check(name, 32'(k < budget), 32'd1);
    cyc();
  endtask

  task automatic clear_run();
    run_clr = 1'b1;
    cyc();
    run_clr = 1'b0;
  endtask

  logic cap [0:511];
  task automatic capture(output int cnt);
    int k;
    k = 0;
    cnt = 0;
    while (!busy && k < 10) begin cyc(); k++; end
    while (busy && cnt < 512) begin
      cap[cnt] = tx;
      cnt++;
      cyc();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] v;
    int n, base, k;
    bit saw_stall, to;
    logic [9:0] pat;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) cyc();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rd(4'h1, v); check("rst_status", 32'(v), 32'h00);
    rd(4'h0, v); check("rst_div", 32'(v), 32'h3F);
    rst_n = 1'b1;
    check("ready_after_rst", 32'(res_ready), 32'd1);
    cyc();

    // Single frame of 8'hA5 at DIV=3
    wr(4'h0, 8'h03);
    rd(4'h0, v); check("div_rd", 32'(v), 32'h03);
    clear_run();
    send_res(8'hA5);
    capture(n);
`ifndef RESULT_TX_PARITY_EN
    pat = 10'b1101001010;
    check("a5_len", 32'(n), 32'd40);
    for (int i = 0; i < 40; i++) check("a5_bit", 32'(cap[i]), 32'(pat[i/4]));
`else
    check("a5_len", 32'(n), 32'd44);
`endif
    wait_idle("a5_idle", 100);

    // Host writes fill the FIFO, then overflow and clear
    wr(4'h2, 8'h11); wr(4'h2, 8'h22); wr(4'h2, 8'h33);
    wr(4'h2, 8'h44); wr(4'h2, 8'h55);
    rd(4'h1, v); check("fill_status", 32'(v), 32'h34);
    wr(4'h2, 8'h66);
    rd(4'h1, v); check("ovf_status", 32'(v), 32'h74);
    wr(4'h1, 8'h00);
    rd(4'h1, v); check("ovf_clear", 32'(v), 32'h34);
    wait_idle("host_idle", 600);

    // Streamed results with backpressure
    base = sent_q.size();
    clear_run();
    saw_stall = 1'b0;
    to = 1'b0;
    res_valid = 1'b1;
    for (int d = 1; d <= 6; d++) begin
      res_data = 8'(d);
      k = 0;
      while (!res_ready && k < 500) begin saw_stall = 1'b1; cyc(); k++; end
      if (k >= 500) to = 1'b1;
      cyc();
    end
    res_valid = 1'b0;
    check("stream_timeout", 32'(to), 32'd0);
    check("stream_stall", 32'(saw_stall), 32'd1);
    wait_idle("stream_idle", 800);
    check("stream_run", 32'(max_run), 32'(6 * 4 * NB));
    check("stream_count", 32'(sent_q.size() - base), 32'd6);
    for (int i = 0; i < 6; i++)
      if (base + i < sent_q.size()) check("stream_order", 32'(sent_q[base+i]), 32'(i + 1));

    // DIV change mid-frame applies to the next frame
    clear_run();
    send_res(8'h5A);
    send_res(8'hC3);
    repeat (10) cyc();
    wr(4'h0, 8'h07);
    wait_idle("div_idle", 600);
    check("div_run", 32'(max_run), 32'(4 * NB + 8 * NB));
    rd(4'h0, v); check("div_new", 32'(v), 32'h07);

    // Asynchronous reset in the middle of DATA
    wr(4'h0, 8'h03);
    send_res(8'h81); send_res(8'h42); send_res(8'h24);
    repeat (12) cyc();
    address = 4'h1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_status", 32'(data_out), 32'h00);
    cyc(); cyc();
    rst_n = 1'b1;
    check("arst_ready", 32'(res_ready), 32'd1);
    repeat (5) cyc();
    check("arst_discard", 32'(busy), 32'd0);
    rd(4'h1, v); check("arst_status2", 32'(v), 32'h00);

`ifdef RESULT_TX_PARITY_EN
    // Parity bit
    wr(4'h0, 8'h01);
    send_res(8'h07);
    capture(n);
    check("par07_len", 32'(n), 32'd22);
    check("par07_bit", 32'(cap[18]), 32'd1);
    check("par07_stop", 32'(cap[20]), 32'd1);
    wait_idle("par07_idle", 100);
    send_res(8'h03);
    capture(n);
    check("par03_bit", 32'(cap[18]), 32'd0);
    wait_idle("par03_idle", 100);
`endif

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
